// File: rtl/nand2.sv
// Bitwise 2-input NAND with a registered observation side: result flop, change pulse, saturating change counter.
// Build option NAND2_PARITY_EN adds o_par, the XOR reduction of o_q.
module nand2 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] o_q,
    output logic             chg,
    output logic [CNT_W-1:0] chg_cnt
`ifdef NAND2_PARITY_EN
    ,
    output logic             o_par
`endif
);

    logic [WIDTH-1:0] nxt_s;
    logic             diff_s;
    logic [CNT_W-1:0] cnt_nxt_s;

    // NAND result and next-state decode for the change counter
    always_comb begin
        nxt_s  = ~(a & b);
        diff_s = (nxt_s != o_q);
        if (diff_s && (chg_cnt != {CNT_W{1'b1}})) begin
            cnt_nxt_s = chg_cnt + CNT_W'(1);
        end else begin
            cnt_nxt_s = chg_cnt;
        end
    end

    // o stays live through reset; it never passes through the flops
    assign o = nxt_s;

    // Registered result, change pulse and saturating counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_q     <= {WIDTH{1'b1}};
            chg     <= 1'b0;
            chg_cnt <= {CNT_W{1'b0}};
        end else begin
            o_q     <= nxt_s;
            chg     <= diff_s;
            chg_cnt <= cnt_nxt_s;
        end
    end

`ifdef NAND2_PARITY_EN
    function automatic logic parity_of(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    // Parity registered alongside o_q so the two never disagree
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_par <= parity_of({WIDTH{1'b1}});
        end else begin
            o_par <= parity_of(nxt_s);
        end
    end
`endif

endmodule

// File: tb/tb_nand2.sv
// Scoreboard bench for nand2: stimulus queues expected values, a monitor pops and compares on each sample event.
`timescale 1ns/1ps
module tb_nand2;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst = 1'b0;
    logic       a1 = 1'b0, b1 = 1'b0;
    logic [3:0] a4 = 4'h0, b4 = 4'h0;
    logic       as = 1'b0, bs = 1'b0;

    logic        o1, oq1, chg1, o_s, oq_s, chg_s;
    logic [15:0] cnt1, cnt4;
    logic [3:0]  o4, oq4;
    logic        chg4;
    logic [1:0]  cnt_s;
`ifdef NAND2_PARITY_EN
    logic par1, par4, par_s;
`endif

    nand2 #(.WIDTH(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .o(o1), .o_q(oq1), .chg(chg1), .chg_cnt(cnt1)
`ifdef NAND2_PARITY_EN
        , .o_par(par1)
`endif
    );

    nand2 #(.WIDTH(4), .CNT_W(16)) u4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .o(o4), .o_q(oq4), .chg(chg4), .chg_cnt(cnt4)
`ifdef NAND2_PARITY_EN
        , .o_par(par4)
`endif
    );

    nand2 #(.WIDTH(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .a(as), .b(bs), .o(o_s), .o_q(oq_s), .chg(chg_s), .chg_cnt(cnt_s)
`ifdef NAND2_PARITY_EN
        , .o_par(par_s)
`endif
    );

    always #5 if (clk_en) clk = ~clk;

    typedef struct {
        string       nm;
        int          dut;
        int          fld;
        logic [31:0] v;
    } sb_t;

    sb_t  sb[$];
    event smp;
    int   checks = 0;
    int   failures = 0;

    localparam int F_O = 0, F_OQ = 1, F_CHG = 2, F_CNT = 3, F_PAR = 4;

    function automatic logic [31:0] actual(input int dut, input int fld);
        logic [31:0] r;
        r = 32'hFFFF_FFFF;
        case (dut)
            1: case (fld)
                F_O:   r = {31'd0, o1};
                F_OQ:  r = {31'd0, oq1};
                F_CHG: r = {31'd0, chg1};
                F_CNT: r = {16'd0, cnt1};
`ifdef NAND2_PARITY_EN
                F_PAR: r = {31'd0, par1};
`endif
                default: r = 32'hFFFF_FFFF;
            endcase
            4: case (fld)
                F_O:   r = {28'd0, o4};
                F_OQ:  r = {28'd0, oq4};
                F_CHG: r = {31'd0, chg4};
                F_CNT: r = {16'd0, cnt4};
`ifdef NAND2_PARITY_EN
                F_PAR: r = {31'd0, par4};
`endif
                default: r = 32'hFFFF_FFFF;
            endcase
            default: case (fld)
                F_O:   r = {31'd0, o_s};
                F_OQ:  r = {31'd0, oq_s};
                F_CHG: r = {31'd0, chg_s};
                F_CNT: r = {30'd0, cnt_s};
`ifdef NAND2_PARITY_EN
                F_PAR: r = {31'd0, par_s};
`endif
                default: r = 32'hFFFF_FFFF;
            endcase
        endcase
        return r;
    endfunction

    // Monitor: drain every queued expectation against the DUT outputs present now
    initial begin
        forever begin
            @(smp);
            while (sb.size() > 0) begin
                sb_t e;
                logic [31:0] act;
                e = sb.pop_front();
                act = actual(e.dut, e.fld);
                checks++;
                if (act !== e.v) begin
                    failures++;
                    $display("FAIL %s: got %0h expected %0h at %0t", e.nm, act, e.v, $time);
                end
            end
        end
    end

    task automatic expect_v(input string nm, input int dut, input int fld, input logic [31:0] v);
        sb.push_back('{nm, dut, fld, v});
    endtask

    task automatic sample();
        -> smp;
        #0.1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #1;
        expect_v("rst_oq1", 1, F_OQ, 32'h1);
        expect_v("rst_chg1", 1, F_CHG, 32'h0);
        expect_v("rst_cnt1", 1, F_CNT, 32'h0);
        expect_v("rst_oq4", 4, F_OQ, 32'hF);
        expect_v("rst_cnt4", 4, F_CNT, 32'h0);
`ifdef NAND2_PARITY_EN
        expect_v("rst_par4", 4, F_PAR, 32'h0);
        expect_v("rst_par1", 1, F_PAR, 32'h1);
`endif
        sample();
        rst = 1'b0;

        // Combinational truth table, no clock, 1 unit between steps
        a1 = 1'b0; b1 = 1'b0;
        #10;
        expect_v("tt_00", 1, F_O, 32'h1); sample();
        a1 = 1'b0; b1 = 1'b1; #0.5;
        expect_v("tt_01", 1, F_O, 32'h1); sample();
        #0.4;
        a1 = 1'b1; b1 = 1'b0; #0.5;
        expect_v("tt_10", 1, F_O, 32'h1); sample();
        #0.4;
        a1 = 1'b1; b1 = 1'b1; #0.5;
        expect_v("tt_11", 1, F_O, 32'h0); sample();
        expect_v("tt_no_clk_oq1", 1, F_OQ, 32'h1); sample();

        a4 = 4'b1100; b4 = 4'b1010; #0.5;
        expect_v("w4_comb", 4, F_O, 32'h7); sample();

        // Clocked: a1=b1=1 then a1=0 on consecutive edges
        clk_en = 1'b1;
        tick();
        expect_v("e1_oq1", 1, F_OQ, 32'h0);
        expect_v("e1_chg1", 1, F_CHG, 32'h1);
        expect_v("e1_cnt1", 1, F_CNT, 32'h1);
        expect_v("e1_oq4", 4, F_OQ, 32'h7);
        expect_v("e1_cnt4", 4, F_CNT, 32'h1);
`ifdef NAND2_PARITY_EN
        expect_v("e1_par4", 4, F_PAR, 32'h1);
`endif
        sample();
        a1 = 1'b0;
        tick();
        expect_v("e2_chg1", 1, F_CHG, 32'h1);
        expect_v("e2_cnt1", 1, F_CNT, 32'h2);
        expect_v("e2_oq1", 1, F_OQ, 32'h1);
        expect_v("e2_chg4", 4, F_CHG, 32'h0);
        expect_v("e2_cnt4", 4, F_CNT, 32'h1);
        sample();
        tick();
        expect_v("e3_chg1", 1, F_CHG, 32'h0);
        expect_v("e3_cnt1", 1, F_CNT, 32'h2);
        sample();

        // Glitch between edges: o follows, registered side does not
        a1 = 1'b1; #1;
        expect_v("glitch_o_lo", 1, F_O, 32'h0); sample();
        a1 = 1'b0; #1;
        expect_v("glitch_o_hi", 1, F_O, 32'h1); sample();
        tick();
        expect_v("e4_chg1", 1, F_CHG, 32'h0);
        expect_v("e4_cnt1", 1, F_CNT, 32'h2);
        expect_v("e4_oq1", 1, F_OQ, 32'h1);
        sample();

        // Saturation: CNT_W=2, toggle every edge
        for (int k = 1; k <= 6; k++) begin
            as = k[0]; bs = k[0];
            tick();
            expect_v($sformatf("sat_cnt_%0d", k), 2, F_CNT, (k < 3) ? k : 3);
            expect_v($sformatf("sat_chg_%0d", k), 2, F_CHG, 32'h1);
            expect_v($sformatf("sat_oq_%0d", k), 2, F_OQ, {31'd0, ~k[0]});
            sample();
        end
        as = 1'b0; bs = 1'b0;

        // Asynchronous reset mid-operation with a=b=all ones
        a4 = 4'hF; b4 = 4'hF;
        a1 = 1'b0; b1 = 1'b0;
        #1 rst = 1'b1;
        #0.5;
        expect_v("ar_o4", 4, F_O, 32'h0);
        expect_v("ar_oq4", 4, F_OQ, 32'hF);
        expect_v("ar_chg4", 4, F_CHG, 32'h0);
        expect_v("ar_cnt4", 4, F_CNT, 32'h0);
        expect_v("ar_cnt1", 1, F_CNT, 32'h0);
        expect_v("ar_cnt_sat", 2, F_CNT, 32'h0);
`ifdef NAND2_PARITY_EN
        expect_v("ar_par4", 4, F_PAR, 32'h0);
`endif
        sample();
        tick();
        expect_v("ar_hold_o4", 4, F_O, 32'h0);
        expect_v("ar_hold_oq4", 4, F_OQ, 32'hF);
        expect_v("ar_hold_cnt4", 4, F_CNT, 32'h0);
        sample();
        rst = 1'b0;

        // First edge after release compares against all ones
        tick();
        expect_v("post_oq4", 4, F_OQ, 32'h0);
        expect_v("post_chg4", 4, F_CHG, 32'h1);
        expect_v("post_cnt4", 4, F_CNT, 32'h1);
        expect_v("post_chg1", 1, F_CHG, 32'h0);
        expect_v("post_cnt1", 1, F_CNT, 32'h0);
        expect_v("post_chg_sat", 2, F_CHG, 32'h0);
`ifdef NAND2_PARITY_EN
        expect_v("post_par4", 4, F_PAR, 32'h0);
`endif
        sample();

        #5;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
